// File: rtl/uart_tx_sched.sv
//============================================================================
// Module  : uart_tx_sched
// Brief   : Pops bytes from the TX FIFO read port, launches each one to the
//           UART transmitter and follows its busy handshake until the frame
//           ends. Keeps a sent-frame counter and a sticky timeout flag.
//           Optional SCHED_GAP_EN inserts GAP_CYCLES idle cycles per frame.
// Revision: 1.0 - initial release
//============================================================================
`default_nettype none

module uart_tx_sched #(
   parameter int DATA_WIDTH   = 8,
   parameter int BUSY_TIMEOUT = 255,
   parameter int GAP_CYCLES   = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable_i,
   input  logic                  fifo_empty_i,
   input  logic [DATA_WIDTH-1:0] fifo_rdata_i,
   output logic                  fifo_inc_o,
   output logic [DATA_WIDTH-1:0] tx_data_o,
   output logic                  tx_valid_o,
   input  logic                  tx_busy_i,
   output logic [15:0]           sent_count_o,
   output logic                  timeout_err_o
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LAUNCH  = 3'd1,
      S_WAIT_HI = 3'd2,
      S_WAIT_LO = 3'd3
`ifdef SCHED_GAP_EN
      ,S_GAP    = 3'd4
`endif
   } state_t;

   localparam logic [7:0] C_TMO_LAST = 8'(BUSY_TIMEOUT - 1);
`ifdef SCHED_GAP_EN
   localparam logic [7:0] C_GAP_LAST = 8'(GAP_CYCLES - 1);
`endif

   // Parameter range guards; both counters share one 8-bit timer.
   if (BUSY_TIMEOUT < 1 || BUSY_TIMEOUT > 255) begin : g_busy_timeout_range
      $error("BUSY_TIMEOUT must be in 1..255");
   end
   if (GAP_CYCLES < 1 || GAP_CYCLES > 255) begin : g_gap_cycles_range
      $error("GAP_CYCLES must be in 1..255");
   end

   state_t                state_q, state_d;
   logic [7:0]            timer_q, timer_d;
   logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
   logic                  fifo_inc_q, fifo_inc_d;
   logic                  tx_valid_q, tx_valid_d;
   logic [15:0]           sent_count_q, sent_count_d;
   logic                  timeout_err_q, timeout_err_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         timer_q       <= 8'd0;
         tx_data_q     <= '0;
         fifo_inc_q    <= 1'b0;
         tx_valid_q    <= 1'b0;
         sent_count_q  <= 16'd0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         timer_q       <= timer_d;
         tx_data_q     <= tx_data_d;
         fifo_inc_q    <= fifo_inc_d;
         tx_valid_q    <= tx_valid_d;
         sent_count_q  <= sent_count_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      timer_d       = timer_q;
      tx_data_d     = tx_data_q;
      fifo_inc_d    = 1'b0;
      tx_valid_d    = 1'b0;
      sent_count_d  = sent_count_q;
      timeout_err_d = timeout_err_q;

      case (state_q)
         S_IDLE: begin
            if (enable_i && !fifo_empty_i) begin
               tx_data_d  = fifo_rdata_i;
               fifo_inc_d = 1'b1;
               tx_valid_d = 1'b1;
               state_d    = S_LAUNCH;
            end
         end
         S_LAUNCH: begin
            timer_d = 8'd0;
            state_d = S_WAIT_HI;
         end
         S_WAIT_HI: begin
            // The byte is already popped; on timeout it is simply dropped.
            if (tx_busy_i) begin
               state_d = S_WAIT_LO;
            end else if (timer_q == C_TMO_LAST) begin
               timeout_err_d = 1'b1;
               timer_d       = 8'd0;
               state_d       = S_IDLE;
            end else begin
               timer_d = timer_q + 8'd1;
            end
         end
         S_WAIT_LO: begin
            if (!tx_busy_i) begin
               sent_count_d = sent_count_q + 16'd1;
`ifdef SCHED_GAP_EN
               timer_d      = 8'd0;
               state_d      = S_GAP;
`else
               state_d      = S_IDLE;
`endif
            end
         end
`ifdef SCHED_GAP_EN
         S_GAP: begin
            if (timer_q == C_GAP_LAST) begin
               timer_d = 8'd0;
               state_d = S_IDLE;
            end else begin
               timer_d = timer_q + 8'd1;
            end
         end
`endif
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign fifo_inc_o    = fifo_inc_q;
   assign tx_data_o     = tx_data_q;
   assign tx_valid_o    = tx_valid_q;
   assign sent_count_o  = sent_count_q;
   assign timeout_err_o = timeout_err_q;

endmodule

`default_nettype wire

// File: doc/uart_tx_sched.md
# uart_tx_sched

Read-side scheduler between the TX async FIFO and the UART transmitter. It pops one byte at a time from the FIFO read port and launches it with a single-cycle valid pulse. It then tracks the transmitter's busy handshake until the frame completes before popping the next byte. It also keeps a sent-frame counter and a sticky handshake-timeout flag for the system controller.

## Interface
Parameters:
- DATA_WIDTH, 8, FIFO/UART data width
- BUSY_TIMEOUT, 255, max cycles to wait for tx_busy to rise after launch (1..255)
- GAP_CYCLES, 16, idle cycles inserted after each frame (1..255; only with SCHED_GAP_EN)

Ports:
- clk  in  1  single clock (FIFO read domain = UART TX domain)
- rst  in  1  synchronous, active-high reset
- enable  in  1  scheduling enable; sampled only in IDLE
- fifo_empty  in  1  FIFO empty flag (read domain)
- fifo_rdata  in  DATA_WIDTH  FIFO head data, valid whenever fifo_empty=0
- fifo_inc  out  1  read-pointer increment pulse
- tx_data  out  DATA_WIDTH  byte presented to UART TX
- tx_valid  out  1  one-cycle launch pulse
- tx_busy  in  1  UART TX frame in progress
- sent_count  out  16  completed frames, wraps 0xFFFF→0x0000
- timeout_err  out  1  sticky: tx_busy never rose after a launch

## Operation
- All outputs are registered. Reset values: fifo_inc=0, tx_valid=0, tx_data=0, sent_count=0, timeout_err=0, state=IDLE, timers=0.
- States: IDLE, LAUNCH, WAIT_HI, WAIT_LO, GAP (GAP exists only with SCHED_GAP_EN).
- IDLE: when enable=1 and fifo_empty=0 at an edge:
  - tx_data <= fifo_rdata; fifo_inc <= 1; tx_valid <= 1; go to LAUNCH.
  - Otherwise stay in IDLE. tx_data holds its last value.
- LAUNCH: fifo_inc and tx_valid are high for exactly this one cycle. Clear the timeout timer; go to WAIT_HI.
- WAIT_HI:
  - tx_busy=1 → go to WAIT_LO.
  - Otherwise increment the timer. When the timer reaches BUSY_TIMEOUT, set timeout_err=1 and go to IDLE. The byte is dropped and not counted.
- WAIT_LO: tx_busy=0 → sent_count += 1, then go to GAP (with SCHED_GAP_EN) or IDLE (without). No timeout applies in this state.
- GAP: count GAP_CYCLES cycles, then go to IDLE.
- enable is ignored outside IDLE. Deasserting enable mid-frame lets the current frame finish and then holds in IDLE.
- timeout_err clears only on rst.
- fifo_inc is never asserted while fifo_empty=1.

## Timing
- Edge k: IDLE samples enable=1 and fifo_empty=0. Cycle k+1: fifo_inc=1, tx_valid=1, tx_data is valid. tx_data stays stable until the next launch.
- tx_busy=1 sampled at cycle k+1 itself is ignored. Busy is checked from WAIT_HI (cycle k+2) onward.
- The FIFO empty flag lags the pop by up to 2 cycles. The shortest path back to IDLE is 3 cycles after LAUNCH, so fifo_empty is always current when next sampled.
- Back-to-back throughput without gap: frame end (tx_busy falls at edge m) → IDLE at m+1 → next tx_valid at m+2.
- Timeout: with tx_busy held low, timeout_err rises BUSY_TIMEOUT cycles after LAUNCH (±1 cycle). The FSM is in IDLE on the following cycle.
- sent_count updates on the edge at which WAIT_LO sees tx_busy=0.
- rst mid-frame: at the next edge, all outputs and the state return to reset values. A pending fifo_inc pulse is cancelled.

## Configuration
- SCHED_GAP_EN defined:
  - The GAP state is present.
  - Exactly GAP_CYCLES idle cycles separate tx_busy falling from the next IDLE evaluation, so the next tx_valid comes GAP_CYCLES+2 cycles after the frame ends.
- SCHED_GAP_EN undefined:
  - The GAP state and its counter are removed, and GAP_CYCLES is ignored.
  - WAIT_LO goes directly to IDLE.

## Test plan
- Single byte: FIFO holds 0xA5, enable=1, UART model raises busy 1 cycle after tx_valid and holds it 10 cycles → expect one tx_valid/fifo_inc pulse with tx_data=0xA5, and sent_count=1 after busy falls.
- Burst: FIFO preloaded with 0x01..0x08 → expect eight launches in order and sent_count=8. Without SCHED_GAP_EN, each tx_valid comes 2 cycles after the previous busy fall. With SCHED_GAP_EN and GAP_CYCLES=16, the spacing is 18 cycles.
- Timeout: tx_busy tied 0, BUSY_TIMEOUT=20, one byte 0x3C → expect timeout_err=1 within 21 cycles of tx_valid, sent_count=0, and timeout_err still 1 after the FIFO is refilled and a later frame completes.
- Enable gating: drop enable during WAIT_LO with 3 bytes queued → expect the current frame to complete (sent_count +1), no further fifo_inc while enable=0, and resumption on re-enable.
- Empty boundary: pop the last byte, then write a new byte 1 cycle after frame end → no fifo_inc while fifo_empty=1, and the new byte launches once empty drops.
- Reset mid-frame: assert rst for 1 cycle during WAIT_HI → next cycle all outputs are 0, state is IDLE, and there is no extra fifo_inc.
